// File: rtl/my_soc_pipe_pkg.sv
// Shared EX-stage pipeline definitions: forward select codes and the shadow
// destination-register slot carried alongside the EX, MEM and WB stages.
package my_soc_pipe_pkg;

    // Slot rd field is wide enough for any register file up to 256 entries;
    // narrower indices are zero-extended on the way in.
    localparam int SLOT_RD_W = 8;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } pipe_slot_t;

    localparam pipe_slot_t SLOT_EMPTY = '0;

    // A slot can only be a hazard source if it really writes a non-x0 register.
    function automatic logic slot_writes(input pipe_slot_t s);
        return s.valid & s.reg_write & (s.rd != '0);
    endfunction

    function automatic logic slot_hits(input pipe_slot_t s,
                                       input logic [SLOT_RD_W-1:0] src);
        return slot_writes(s) & (s.rd == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forward select for one EX source: picks the youngest in-flight
// producer of src among the EX/MEM and MEM/WB slots.
module fwd_select
    import my_soc_pipe_pkg::*;
(
    input  logic [SLOT_RD_W-1:0] src,
    input  logic                 uses,
    input  pipe_slot_t           ex_mem_slot,
    input  pipe_slot_t           mem_wb_slot,
    output logic [1:0]           sel
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = uses & slot_hits(ex_mem_slot, src);
    assign mem_wb_hit = uses & slot_hits(mem_wb_slot, src);

    always_comb begin
        sel = FWD_NONE;
        if (ex_mem_hit)
            sel = FWD_EX_MEM;
        else if (mem_wb_hit)
            sel = FWD_MEM_WB;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage hazard unit: shadow rd pipeline, registered forward selects for the
// instruction entering EX, and the load-use stall with a saturating counter.
module hazard_forward_ctrl
    import my_soc_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_busy,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_id,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int NUM_SRC = 2;

    pipe_slot_t ex_slot;
    pipe_slot_t mem_slot;
    pipe_slot_t wb_slot;
    pipe_slot_t id_slot;

    logic [NUM_SRC-1:0][SLOT_RD_W-1:0] src_idx;
    logic [NUM_SRC-1:0]                src_uses;
    logic [NUM_SRC-1:0][1:0]           fwd_sel;
    logic [NUM_SRC-1:0][1:0]           fwd_q;
    logic [NUM_SRC-1:0]                load_use_hit;

    logic advance;
    logic ex_bubble;

    assign src_idx[0]  = SLOT_RD_W'(id_rs1);
    assign src_idx[1]  = SLOT_RD_W'(id_rs2);
    assign src_uses[0] = id_uses_rs1;
    assign src_uses[1] = id_uses_rs2;

    always_comb begin
        id_slot           = SLOT_EMPTY;
        id_slot.valid     = id_valid;
        id_slot.rd        = SLOT_RD_W'(id_rd);
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    // The current EX and MEM slots are exactly what will sit in EX/MEM and
    // MEM/WB once the ID instruction has moved into EX.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_select u_fwd_select (
            .src         (src_idx[s]),
            .uses        (src_uses[s]),
            .ex_mem_slot (ex_slot),
            .mem_wb_slot (mem_slot),
            .sel         (fwd_sel[s])
        );

        assign load_use_hit[s] = src_uses[s] & slot_hits(ex_slot, src_idx[s]);
    end

    // A taken flush kills the consumer, so there is nothing left to stall.
    assign stall_id  = id_valid & ex_slot.mem_read & (|load_use_hit) & ~flush;

    assign advance   = ~mem_busy;
    assign ex_bubble = flush | stall_id | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
            wb_slot  <= SLOT_EMPTY;
        end else if (advance) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= ex_bubble ? SLOT_EMPTY : id_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
        end else if (advance) begin
            for (int s = 0; s < NUM_SRC; s++)
                fwd_q[s] <= ex_bubble ? FWD_NONE : fwd_sel[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (advance && stall_id && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

    assign forward_a = fwd_q[0];
    assign forward_b = fwd_q[1];

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a driver issues one ID instruction per
// cycle and queues the hand-computed outputs; a monitor pops and compares.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic        flush, mem_busy;
    logic [1:0]  forward_a, forward_b;
    logic        stall_id;
    logic [15:0] stall_count;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic rst_q  = 1'b0;
    logic busy_q = 1'b0;
    logic fl_q   = 1'b0;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .flush       (flush),
        .mem_busy    (mem_busy),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall_id    (stall_id),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // One ID-stage cycle plus the outputs expected while it is presented.
    task automatic ins(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [1:0] efa, input logic [1:0] efb, input logic est,
                       input logic [15:0] ecnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = ~rst_q;  id_valid = v;  id_rd = rd;  id_reg_write = rw;  id_mem_read = mr;
        id_rs1 = rs1;  id_uses_rs1 = u1;  id_rs2 = rs2;  id_uses_rs2 = u2;
        flush = fl_q;  mem_busy = busy_q;
        e.fa = efa;  e.fb = efb;  e.st = est;  e.cnt = ecnt;  e.name = name;
        sb.push_back(e);
    endtask

    task automatic nop(input logic [1:0] efa, input logic [1:0] efb, input logic [15:0] ecnt,
                       input string name);
        ins(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, efa, efb, 1'b0, ecnt, name);
    endtask

    task automatic drain(input logic [15:0] ecnt, input string name);
        for (int i = 0; i < 3; i++) nop(2'b00, 2'b00, ecnt, name);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (forward_a !== e.fa || forward_b !== e.fb || stall_id !== e.st ||
                stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got fa=%b fb=%b stall=%b cnt=%0d, expected fa=%b fb=%b stall=%b cnt=%0d",
                         e.name, forward_a, forward_b, stall_id, stall_count,
                         e.fa, e.fb, e.st, e.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;  id_valid = 0;  id_rs1 = 0;  id_rs2 = 0;  id_rd = 0;
        id_uses_rs1 = 0;  id_uses_rs2 = 0;  id_reg_write = 0;  id_mem_read = 0;
        flush = 0;  mem_busy = 0;

        rst_q = 1'b1;
        nop(2'b00, 2'b00, 16'd0, "reset");
        nop(2'b00, 2'b00, 16'd0, "reset_hold");
        rst_q = 1'b0;
        drain(16'd0, "post_reset");

        // 1: add x5,x1,x2 ; add x6,x5,x1
        ins(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "exmem_prod");
        ins(1, 5'd6, 1, 0, 5'd5, 1, 5'd1, 1, 2'b00, 2'b00, 0, 16'd0, "exmem_cons_id");
        nop(2'b10, 2'b00, 16'd0, "exmem_fwd_a");
        drain(16'd0, "drain1");

        // 2: add x5 ; nop ; sub x7,x1,x5
        ins(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "memwb_prod");
        nop(2'b00, 2'b00, 16'd0, "memwb_gap");
        ins(1, 5'd7, 1, 0, 5'd1, 1, 5'd5, 1, 2'b00, 2'b00, 0, 16'd0, "memwb_cons_id");
        nop(2'b00, 2'b01, 16'd0, "memwb_fwd_b");
        drain(16'd0, "drain2");

        // 3: add x5 ; add x5 ; or x8,x5,x5
        ins(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "dbl_prod1");
        ins(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "dbl_prod2");
        ins(1, 5'd8, 1, 0, 5'd5, 1, 5'd5, 1, 2'b00, 2'b00, 0, 16'd0, "dbl_cons_id");
        nop(2'b10, 2'b10, 16'd0, "dbl_youngest");
        drain(16'd0, "drain3");

        // 4: lw x4,(x3) ; add x9,x4,x2
        ins(1, 5'd4, 1, 1, 5'd3, 1, 5'd0, 0, 2'b00, 2'b00, 0, 16'd0, "lu_load");
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 1, 16'd0, "lu_stall");
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd1, "lu_bubble");
        nop(2'b01, 2'b00, 16'd1, "lu_fwd_memwb");
        drain(16'd1, "drain4");

        // 5a: addi x0,x1 ; add x10,x0,x0
        ins(1, 5'd0, 1, 0, 5'd1, 1, 5'd0, 0, 2'b00, 2'b00, 0, 16'd1, "x0_prod");
        ins(1, 5'd10, 1, 0, 5'd0, 1, 5'd0, 1, 2'b00, 2'b00, 0, 16'd1, "x0_cons_id");
        nop(2'b00, 2'b00, 16'd1, "x0_no_fwd");
        drain(16'd1, "drain5a");

        // 5b: lw x4 ; consumer killed by flush
        ins(1, 5'd4, 1, 1, 5'd3, 1, 5'd0, 0, 2'b00, 2'b00, 0, 16'd1, "fl_load");
        fl_q = 1'b1;
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd1, "fl_no_stall");
        fl_q = 1'b0;
        nop(2'b00, 2'b00, 16'd1, "fl_bubble");
        drain(16'd1, "drain5b");

        // 6a: freeze while a forward select is live
        ins(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd1, "frz_prod");
        ins(1, 5'd6, 1, 0, 5'd5, 1, 5'd1, 1, 2'b00, 2'b00, 0, 16'd1, "frz_cons_id");
        busy_q = 1'b1;
        for (int i = 0; i < 3; i++) nop(2'b10, 2'b00, 16'd1, "frz_hold_fwd");
        busy_q = 1'b0;
        nop(2'b10, 2'b00, 16'd1, "frz_release");
        drain(16'd1, "drain6a");

        // 6b: freeze during a load-use stall; count must not advance
        ins(1, 5'd4, 1, 1, 5'd3, 1, 5'd0, 0, 2'b00, 2'b00, 0, 16'd1, "frz_load");
        busy_q = 1'b1;
        for (int i = 0; i < 3; i++)
            ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 1, 16'd1, "frz_stall_hold");
        busy_q = 1'b0;
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 1, 16'd1, "frz_stall_go");
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd2, "frz_bubble");
        nop(2'b01, 2'b00, 16'd2, "frz_fwd_memwb");
        drain(16'd2, "drain6b");

        // 6c: reset asserted mid-stall while frozen
        ins(1, 5'd4, 1, 1, 5'd3, 1, 5'd0, 0, 2'b00, 2'b00, 0, 16'd2, "rst_load");
        busy_q = 1'b1;
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 1, 16'd2, "rst_pending");
        rst_q = 1'b1;
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "rst_async_clear");
        rst_q  = 1'b0;
        busy_q = 1'b0;
        ins(1, 5'd9, 1, 0, 5'd4, 1, 5'd2, 1, 2'b00, 2'b00, 0, 16'd0, "rst_no_stall");
        nop(2'b00, 2'b00, 16'd0, "rst_cons_no_fwd");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
